// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath defaults, branch-type encoding
// (also used by the decoder) and the EX/MEM stage state type.
package mips_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned REGW_DEF  = 5;

    typedef enum logic [1:0] {
        BrNone = 2'b00,
        BrBeq  = 2'b01,
        BrBne  = 2'b10
    } br_type_e;

    typedef enum logic {
        StRun    = 1'b0,
        StSquash = 1'b1
    } exmem_state_e;

    // Decoder flags are mutually exclusive; beq wins if both are ever set.
    function automatic br_type_e br_type_of(input logic is_beq, input logic is_bne);
        br_type_e t;
        if (is_beq) begin
            t = BrBeq;
        end else if (is_bne) begin
            t = BrBne;
        end else begin
            t = BrNone;
        end
        return t;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch resolution: taken decision from the ALU zero flag and
// the PC-relative target pc4 + (imm << 2), wrapping modulo 2^WIDTH.
module branch_cond
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             valid_i,
    input  br_type_e         br_type_i,
    input  logic             zerof_i,
    input  logic [WIDTH-1:0] pc4_i,
    input  logic [WIDTH-1:0] imm_i,
    output logic             taken_o,
    output logic [WIDTH-1:0] target_o
);

    logic cond;

    // The ALU subtracts for branches, so zerof means the operands are equal.
    always_comb begin
        cond = 1'b0;
        case (br_type_i)
            BrBeq:   cond = zerof_i;
            BrBne:   cond = ~zerof_i;
            default: cond = 1'b0;
        endcase
    end

    assign taken_o  = valid_i & cond;
    assign target_o = pc4_i + (imm_i << 2);

endmodule

// File: rtl/branch_resolve_exmem.sv
// EX/MEM pipeline register with beq/bne resolution, registered PC redirect and
// flush, one-cycle wrong-path squash and a saturating taken-branch counter.
module branch_resolve_exmem
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned REGW  = REGW_DEF,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             ex_valid_i,
    input  logic             ex_is_beq_i,
    input  logic             ex_is_bne_i,
    input  logic [WIDTH-1:0] ex_pc4_i,
    input  logic [WIDTH-1:0] ex_imm_i,
    input  logic [WIDTH-1:0] ex_alu_result_i,
    input  logic             ex_zerof_i,
    input  logic [WIDTH-1:0] ex_wdata_i,
    input  logic [REGW-1:0]  ex_rd_i,
    input  logic             ex_regwrite_i,
    input  logic             ex_memread_i,
    input  logic             ex_memwrite_i,
    output logic             mem_valid_o,
    output logic [WIDTH-1:0] mem_alu_result_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    output logic [REGW-1:0]  mem_rd_o,
    output logic             mem_regwrite_o,
    output logic             mem_memread_o,
    output logic             mem_memwrite_o,
    output logic             redirect_o,
    output logic [WIDTH-1:0] target_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    exmem_state_e     state_q;
    logic             taken;
    logic [WIDTH-1:0] target;

    logic             mem_valid_q;
    logic [WIDTH-1:0] mem_alu_result_q;
    logic [WIDTH-1:0] mem_wdata_q;
    logic [REGW-1:0]  mem_rd_q;
    logic             mem_regwrite_q;
    logic             mem_memread_q;
    logic             mem_memwrite_q;
    logic             redirect_q;
    logic [WIDTH-1:0] target_q;
    logic [CNT_W-1:0] cnt_q;

    branch_cond #(
        .WIDTH (WIDTH)
    ) u_branch_cond (
        .valid_i   (ex_valid_i),
        .br_type_i (br_type_of(ex_is_beq_i, ex_is_bne_i)),
        .zerof_i   (ex_zerof_i),
        .pc4_i     (ex_pc4_i),
        .imm_i     (ex_imm_i),
        .taken_o   (taken),
        .target_o  (target)
    );

    // A stall freezes everything, so a pending redirect stays visible to the
    // front end until the memory stage releases the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StRun;
            mem_valid_q      <= 1'b0;
            mem_alu_result_q <= '0;
            mem_wdata_q      <= '0;
            mem_rd_q         <= '0;
            mem_regwrite_q   <= 1'b0;
            mem_memread_q    <= 1'b0;
            mem_memwrite_q   <= 1'b0;
            redirect_q       <= 1'b0;
            target_q         <= '0;
            cnt_q            <= '0;
        end else if (!stall_i) begin
            unique case (state_q)
                StRun: begin
                    mem_valid_q      <= ex_valid_i;
                    mem_alu_result_q <= ex_alu_result_i;
                    mem_wdata_q      <= ex_wdata_i;
                    mem_rd_q         <= ex_rd_i;
                    mem_regwrite_q   <= ex_valid_i & ex_regwrite_i;
                    mem_memread_q    <= ex_valid_i & ex_memread_i;
                    mem_memwrite_q   <= ex_valid_i & ex_memwrite_i;
                    redirect_q       <= taken;
                    if (taken) begin
                        target_q <= target;
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        state_q <= StSquash;
                    end
                end
                StSquash: begin
                    // EX holds the wrong-path instruction: insert a bubble,
                    // leaving the data fields untouched.
                    mem_valid_q    <= 1'b0;
                    mem_regwrite_q <= 1'b0;
                    mem_memread_q  <= 1'b0;
                    mem_memwrite_q <= 1'b0;
                    redirect_q     <= 1'b0;
                    state_q        <= StRun;
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign mem_valid_o      = mem_valid_q;
    assign mem_alu_result_o = mem_alu_result_q;
    assign mem_wdata_o      = mem_wdata_q;
    assign mem_rd_o         = mem_rd_q;
    assign mem_regwrite_o   = mem_regwrite_q;
    assign mem_memread_o    = mem_memread_q;
    assign mem_memwrite_o   = mem_memwrite_q;
    assign redirect_o       = redirect_q;
    assign flush_o          = redirect_q;
    assign target_o         = target_q;
    assign taken_cnt_o      = cnt_q;

endmodule

// File: tb/tb_branch_resolve_exmem.sv
// Bench for branch_resolve_exmem: directed vector table, hand-written stall,
// saturation and reset sequences, then random traffic against a cycle model.
module tb_branch_resolve_exmem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, valid, beq, bne, zerof, rw, mr, mw;
    logic [31:0] pc4, imm, res, wdata;
    logic [4:0]  rd;

    // Instance a: CNT_W=2 (saturation visible); instance b: default CNT_W=16.
    logic        a_valid, a_rw, a_mr, a_mw, a_redirect, a_flush;
    logic [31:0] a_res, a_wdata, a_target;
    logic [4:0]  a_rd;
    logic [1:0]  a_cnt;
    logic        b_valid, b_rw, b_mr, b_mw, b_redirect, b_flush;
    logic [31:0] b_res, b_wdata, b_target;
    logic [4:0]  b_rd;
    logic [15:0] b_cnt;

    always #5 clk = ~clk;

    branch_resolve_exmem #(.WIDTH(32), .REGW(5), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .ex_valid_i(valid),
        .ex_is_beq_i(beq), .ex_is_bne_i(bne), .ex_pc4_i(pc4), .ex_imm_i(imm),
        .ex_alu_result_i(res), .ex_zerof_i(zerof), .ex_wdata_i(wdata), .ex_rd_i(rd),
        .ex_regwrite_i(rw), .ex_memread_i(mr), .ex_memwrite_i(mw),
        .mem_valid_o(a_valid), .mem_alu_result_o(a_res), .mem_wdata_o(a_wdata),
        .mem_rd_o(a_rd), .mem_regwrite_o(a_rw), .mem_memread_o(a_mr),
        .mem_memwrite_o(a_mw), .redirect_o(a_redirect), .target_o(a_target),
        .flush_o(a_flush), .taken_cnt_o(a_cnt)
    );

    branch_resolve_exmem #(.WIDTH(32), .REGW(5), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .ex_valid_i(valid),
        .ex_is_beq_i(beq), .ex_is_bne_i(bne), .ex_pc4_i(pc4), .ex_imm_i(imm),
        .ex_alu_result_i(res), .ex_zerof_i(zerof), .ex_wdata_i(wdata), .ex_rd_i(rd),
        .ex_regwrite_i(rw), .ex_memread_i(mr), .ex_memwrite_i(mw),
        .mem_valid_o(b_valid), .mem_alu_result_o(b_res), .mem_wdata_o(b_wdata),
        .mem_rd_o(b_rd), .mem_regwrite_o(b_rw), .mem_memread_o(b_mr),
        .mem_memwrite_o(b_mw), .redirect_o(b_redirect), .target_o(b_target),
        .flush_o(b_flush), .taken_cnt_o(b_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: the instruction right after a taken branch is wrong-path.
    logic        m_valid, m_rw, m_mr, m_mw, m_redirect, m_wrong_next;
    logic [31:0] m_res, m_wdata, m_target;
    logic [4:0]  m_rd;
    int          m_taken;

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_redirect = 0; m_wrong_next = 0;
        m_res = 0; m_wdata = 0; m_target = 0; m_rd = 0; m_taken = 0;
    endtask

    task automatic model_step();
        logic            tk;
        longint unsigned t;
        if (stall) return;
        if (m_wrong_next) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
            m_redirect = 0; m_wrong_next = 0;
            return;
        end
        m_valid = valid; m_res = res; m_wdata = wdata; m_rd = rd;
        m_rw = valid && rw; m_mr = valid && mr; m_mw = valid && mw;
        tk = valid && ((beq && zerof) || (bne && !zerof));
        m_redirect = tk;
        if (tk) begin
            t = {32'b0, pc4} + {32'b0, imm} * 64'd4;
            m_target = t[31:0];
            m_taken++;
            m_wrong_next = 1;
        end
    endtask

    task automatic check_model(input string tag);
        int s2, s16;
        s2  = (m_taken > 3) ? 3 : m_taken;
        s16 = (m_taken > 65535) ? 65535 : m_taken;
        chk({tag, " valid"}, {a_valid, b_valid}, {m_valid, m_valid});
        chk({tag, " ctl"}, {a_rw, a_mr, a_mw, b_rw, b_mr, b_mw},
            {m_rw, m_mr, m_mw, m_rw, m_mr, m_mw});
        chk({tag, " redir/flush"}, {a_redirect, a_flush, b_redirect, b_flush},
            {4{m_redirect}});
        chk({tag, " res"}, {a_res, b_res}, {m_res, m_res});
        chk({tag, " wdata"}, {a_wdata, b_wdata}, {m_wdata, m_wdata});
        chk({tag, " rd"}, {a_rd, b_rd}, {m_rd, m_rd});
        chk({tag, " target"}, {a_target, b_target}, {m_target, m_target});
        chk({tag, " cnt2"}, 64'(a_cnt), 64'(s2));
        chk({tag, " cnt16"}, 64'(b_cnt), 64'(s16));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " a"}, {a_valid, a_rw, a_mr, a_mw, a_redirect, a_flush, a_res, a_wdata,
                          a_rd, a_target, a_cnt}, 64'd0);
        chk({tag, " a_data"}, {a_res, a_wdata}, 64'd0);
        chk({tag, " b"}, {b_valid, b_rw, b_mr, b_mw, b_redirect, b_flush, b_rd, b_cnt},
            64'd0);
        chk({tag, " b_data"}, {b_res, b_target}, 64'd0);
    endtask

    task automatic drive(input logic st, input logic v, input logic bq, input logic bn,
                         input logic z, input logic w, input logic r, input logic s,
                         input logic [31:0] p, input logic [31:0] i, input logic [31:0] d,
                         input logic [4:0] dst);
        stall = st; valid = v; beq = bq; bne = bn; zerof = z;
        rw = w; mr = r; mw = s; pc4 = p; imm = i; res = d; wdata = d ^ 32'hA5A5_A5A5;
        rd = dst;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        st, v, bq, bn, z, w, r, s;
        logic [31:0] p, i, d;
        logic [4:0]  dst;
        logic        e_valid, e_rw, e_mr, e_mw, e_redir;
        logic [31:0] e_res, e_target;
        int          e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic v, input logic bq, input logic bn,
                                input logic z, input logic w, input logic r, input logic s,
                                input logic [31:0] p, input logic [31:0] i,
                                input logic [31:0] d, input logic [4:0] dst,
                                input logic ev, input logic erw, input logic emr,
                                input logic emw, input logic er, input logic [31:0] eres,
                                input logic [31:0] etgt, input int ecnt);
        vec_t x;
        x.st = st; x.v = v; x.bq = bq; x.bn = bn; x.z = z; x.w = w; x.r = r; x.s = s;
        x.p = p; x.i = i; x.d = d; x.dst = dst;
        x.e_valid = ev; x.e_rw = erw; x.e_mr = emr; x.e_mw = emw; x.e_redir = er;
        x.e_res = eres; x.e_target = etgt; x.e_cnt = ecnt;
        return x;
    endfunction

    vec_t tbl[$];

    initial begin
        int redir_cycles;
        int kind;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        //          st v bq bn z rw mr mw pc4           imm           res           rd
        //          -> valid rw mr mw redir res         target        cnt
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 32'h10, 3,
                         1, 1, 0, 0, 0, 32'h10, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 32'h100, 32'hFFFF_FFFC, 0, 0,
                         1, 0, 0, 0, 1, 0, 32'hF0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 32'h55, 4,
                         0, 0, 0, 0, 0, 0, 32'hF0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 32'h200, 32'h10, 0, 0,
                         1, 0, 0, 0, 0, 0, 32'hF0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h1, 0, 0,
                         1, 0, 0, 0, 1, 0, 32'h0, 2));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 32'h300, 32'h4, 32'h99, 0,
                         0, 0, 0, 0, 0, 0, 32'h0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 32'h77, 7,
                         0, 0, 0, 0, 0, 32'h77, 32'h0, 2));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 32'h400, 32'h8, 0, 0,
                         0, 0, 0, 0, 0, 0, 32'h0, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 32'h1234, 9,
                         1, 1, 1, 0, 0, 32'h1234, 32'h0, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h40, 0,
                         1, 0, 0, 1, 0, 32'h40, 32'h0, 2));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 32'hDEAD, 1,
                         1, 0, 0, 1, 0, 32'h40, 32'h0, 2));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 32'h500, 32'h3, 32'h8, 0,
                         1, 0, 0, 0, 0, 32'h8, 32'h0, 2));

        foreach (tbl[k]) begin
            drive(tbl[k].st, tbl[k].v, tbl[k].bq, tbl[k].bn, tbl[k].z, tbl[k].w, tbl[k].r,
                  tbl[k].s, tbl[k].p, tbl[k].i, tbl[k].d, tbl[k].dst);
            cycle();
            chk($sformatf("vec%0d valid", k), a_valid, tbl[k].e_valid);
            chk($sformatf("vec%0d ctl", k), {a_rw, a_mr, a_mw},
                {tbl[k].e_rw, tbl[k].e_mr, tbl[k].e_mw});
            chk($sformatf("vec%0d redir", k), {a_redirect, a_flush}, {2{tbl[k].e_redir}});
            chk($sformatf("vec%0d res", k), a_res, tbl[k].e_res);
            chk($sformatf("vec%0d target", k), a_target, tbl[k].e_target);
            chk($sformatf("vec%0d cnt16", k), 64'(b_cnt), 64'(tbl[k].e_cnt));
        end

        // Redirect must stay up through a 3-cycle stall, bubble only after release.
        drive(0, 1, 1, 0, 1, 0, 0, 0, 32'h1000, 32'h10, 32'h11, 2);
        cycle();
        redir_cycles = a_redirect ? 1 : 0;
        chk("stall tgt", a_target, 32'h1040);
        drive(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 32'hBAD, 6);
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (a_redirect) redir_cycles++;
            chk("stall hold branch", {a_valid, a_rw, a_res}, {1'b1, 1'b0, 32'h11});
            check_model("stall");
        end
        chk("stall redirect cycles", 64'(redir_cycles), 64'd4);
        stall = 1'b0;
        cycle();
        chk("stall release bubble", {a_valid, a_rw, a_redirect, a_flush}, 4'b0000);
        check_model("release");
        drive(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 32'h22, 8);
        cycle();
        chk("after squash run", {a_valid, a_rw}, 2'b11);

        // Five more taken branches: 2-bit counter saturates at 3.
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 1, 0, 0, 0, 0, 32'h2000 + 32'(k * 16), 32'(k), 0, 0);
            cycle();
            drive(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 32'h33, 1);
            cycle();
        end
        chk("sat cnt2", 64'(a_cnt), 64'd3);
        chk("sat cnt16", 64'(b_cnt), 64'd8);
        check_model("sat");

        // Asynchronous reset in the SQUASH cycle drops the redirect immediately.
        drive(0, 1, 1, 0, 1, 0, 0, 0, 32'h3000, 32'h4, 0, 0);
        cycle();
        chk("pre-reset redirect", a_redirect, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_zero("midsquash reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 1, 0, 1, 0, 0, 0, 32'h40, 32'h2, 0, 0);
        cycle();
        chk("post-reset run", {a_redirect, a_target}, {1'b1, 32'h48});
        check_model("post-reset");

        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 2));
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), (kind == 1),
                  (kind == 2), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
                  $urandom, 5'($urandom));
            wdata = $urandom;
            cycle();
            check_model($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
